// File: rtl/pga_ramp.sv
`default_nettype none
// ============================================================================
// Module   : pga_ramp
// Brief    : Programmable-gain amplifier (real-valued model) with a supply /
//            enable qualified power-up sequence OFF -> WAKE -> ON and a
//            1-LSB-per-cycle gain ramp toward the requested gain code.
// Options  : define PGA_RAMP_CLIP_EN to clamp out to [-vdd, +vdd] and drive
//            clip while the clamp is active; otherwise clip is tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module pga_ramp #(
  parameter int unsigned GAIN_BITS   = 2,
  parameter real         FACTOR      = 10.0,
  parameter int unsigned WAKE_CYCLES = 4,
  parameter real         VDD_MIN     = 0.9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  real                  in,
  input  real                  vdd,
  input  logic                 en,
  input  logic [GAIN_BITS-1:0] amp,
  output real                  out,
  output logic [GAIN_BITS-1:0] gain_code,
  output logic                 ready,
  output logic                 clip
);

  // Counter only has to reach WAKE_CYCLES-1; keep at least one bit so a
  // single-cycle wake still yields a legal vector.
  localparam int unsigned CNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GAIN_BITS-1:0] gain_q, gain_d;
  logic [GAIN_BITS-1:0] target;
  logic                 good;
  real                  prod;

  assign good      = en && (vdd > VDD_MIN);
  assign gain_code = gain_q;

  // Target gain: an undefined code must never steer the ramp, fall back to 0.
  always_comb begin
    target = amp;
    if ($isunknown(amp)) begin
      target = '0;
    end
  end

  // State, wake counter and gain registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      gain_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gain_q  <= gain_d;
    end
  end

  // Next-state logic: power sequencing plus the single-step gain ramp.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gain_d  = gain_q;
    unique case (state_q)
      S_OFF: begin
        cnt_d  = '0;
        gain_d = '0;
        if (good) begin
          state_d = S_WAKE;
        end
      end
      S_WAKE: begin
        gain_d = '0;
        if (!good) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ON: begin
        if (!good) begin
          state_d = S_OFF;
          cnt_d   = '0;
          gain_d  = '0;
        end else if (gain_q < target) begin
          gain_d = gain_q + GAIN_BITS'(1);
        end else if (gain_q > target) begin
          gain_d = gain_q - GAIN_BITS'(1);
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
        gain_d  = '0;
      end
    endcase
  end

  // Output path: live only while ON with a good supply, so a brown-out kills
  // the output immediately, ahead of the OFF transition edge.
  always_comb begin
    prod  = 0.0;
    out   = 0.0;
    clip  = 1'b0;
    ready = (state_q == S_ON) && (gain_q == target) && good;
    if ((state_q == S_ON) && good) begin
      prod = FACTOR * real'(gain_q) * in;
`ifdef PGA_RAMP_CLIP_EN
      if (prod > vdd) begin
        out  = vdd;
        clip = 1'b1;
      end else if (prod < -vdd) begin
        out  = -vdd;
        clip = 1'b1;
      end else begin
        out = prod;
      end
`else
      out = prod;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/pga_ramp.md
PGA_RAMP -- requirements
Module: pga_ramp

Interface
REQ-001 Parameter GAIN_BITS, default 2: width of the gain code, unsigned.
REQ-002 Parameter FACTOR, default 10.0 (real): gain per code LSB.
REQ-003 Parameter WAKE_CYCLES, default 4: wake-up settle time in clk cycles, minimum 1.
REQ-004 Parameter VDD_MIN, default 0.9 (real): supply threshold; supply is good only when vdd > VDD_MIN.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in  input  wreal  analog input.
REQ-008 vdd  input  wreal  supply level.
REQ-009 en  input  1  block enable.
REQ-010 amp  input  GAIN_BITS  target gain code.
REQ-011 out  output  wreal  amplified output.
REQ-012 gain_code  output  GAIN_BITS  gain code currently applied.
REQ-013 ready  output  1  high when the block is in ON and gain_code == target.
REQ-014 clip  output  1  output-saturation flag (see Configuration).

Function
REQ-015 The state machine SHALL have three states: OFF, WAKE, ON; "good" = en==1 && vdd > VDD_MIN.
REQ-016 OFF -> WAKE on the edge where good==1; wake counter cleared.
REQ-017 WAKE: the counter increments each edge; WAKE -> ON on the edge where counter == WAKE_CYCLES-1, so ON is entered WAKE_CYCLES edges after WAKE entry.
REQ-018 From WAKE or ON: good==0 at an edge -> OFF; counter and gain_code cleared to 0.
REQ-019 In ON, target = amp, except that any X/Z bit in amp gives target = 0.
REQ-020 In ON, each edge: gain_code +1 if gain_code < target, -1 if greater, hold if equal; step is 1 LSB per cycle and never wraps.
REQ-021 gain_code SHALL stay 0 in OFF and WAKE; the first increment occurs on the first edge after ON entry.
REQ-022 A target change mid-ramp SHALL redirect the ramp from the current gain_code on the next edge, with no jump.
REQ-023 out SHALL be FACTOR*gain_code*in, combinational on in and gain_code, when state==ON and good==1.
REQ-024 Otherwise out SHALL be 0.0.
REQ-025 out is forced to 0.0 combinationally as soon as good falls, before the OFF transition edge.
REQ-026 ready SHALL be combinational: (state==ON) && (gain_code==target) && good.

Reset
REQ-027 rst==1 at an edge SHALL force state=OFF, counter=0, gain_code=0.
REQ-028 During and after reset, out=0.0, ready=0, clip=0 until normal operation resumes.
REQ-029 rst SHALL take priority over good, including mid-WAKE and mid-ramp.
REQ-030 After rst falls, WAKE entry requires good at a later edge.

Configuration
REQ-031 With macro PGA_RAMP_CLIP_EN defined, out SHALL be clamped to [-vdd, +vdd].
REQ-032 With PGA_RAMP_CLIP_EN defined, clip SHALL be 1 whenever the clamp is active, combinationally.
REQ-033 Without PGA_RAMP_CLIP_EN, there SHALL be no clamping and clip SHALL be tied to 0.

Verification (GAIN_BITS=2, FACTOR=10.0, WAKE_CYCLES=4, VDD_MIN=0.9)
REQ-034 Reset: rst=1 for 2 edges with en=1, vdd=1.2 -> state OFF, gain_code=0, out=0.0, ready=0.
REQ-035 Power-up: vdd=1.2, en=1, amp=3, in=0.05 -> out=0.0 through WAKE (4 edges), then gain_code 1,2,3 on successive edges, out=0.5,1.0,1.5; ready=1 at code 3 only.
REQ-036 Ramp down: amp 3->1 while ON -> gain_code 2 then 1 on consecutive edges; ready=0 then 1.
REQ-037 Brown-out: vdd drops to 0.8 while ON -> out=0.0 immediately, OFF and gain_code=0 at next edge; restore vdd=1.2 -> full 4-cycle WAKE repeated.
REQ-038 Invalid code: amp=2'bx1 while ON at code 2 -> ramps 1, 0; ready=1 at 0.
REQ-039 Clip: in=0.5, code 3, vdd=1.2 -> with PGA_RAMP_CLIP_EN: out=1.2, clip=1; without: out=15.0, clip=0.
